// File: rtl/vend_pkg.sv
// Shared types and sizing helpers for the vending output dispenser.
// The state set and timer width are common to the controller and its bench.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PROD  = 3'd1,
    CHG   = 3'd2,
    GAP   = 3'd3,
    FAULT = 3'd4
  } state_e;

  localparam int unsigned PULSE_LEN_DEF = 4;
  localparam int unsigned GAP_LEN_DEF   = 2;
  localparam int unsigned TIMEOUT_DEF   = 16;
  localparam int unsigned CNT_W_DEF     = 2;

  // The single timer is shared by all timed states, so size it for the longest one.
  function automatic int unsigned timer_width(input int unsigned timeout,
                                              input int unsigned pulse_len,
                                              input int unsigned gap_len);
    int unsigned longest;
    longest = timeout;
    if (pulse_len > longest) longest = pulse_len;
    if (gap_len > longest) longest = gap_len;
    return $clog2(longest) + 1;
  endfunction

  localparam int unsigned TMR_W_DEF = timer_width(TIMEOUT_DEF, PULSE_LEN_DEF, GAP_LEN_DEF);

endpackage

// File: rtl/vend_req_cnt.sv
// Saturating pending-request counter: +1 on inc, -1 on dec, unchanged on both.
// ovf_o pulses when an increment is lost because the counter is already full.
module vend_req_cnt
  import vend_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         ovf_o
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    ovf_o   = 1'b0;
    if (inc_i && !dec_i) begin
      if (count_q == CNT_MAX) begin
        ovf_o = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/vend_dispenser.sv
// Output-side controller: queues product/change strobes and drives the motor
// and coin-return actuators one request at a time with a forced idle gap.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned PULSE_LEN = PULSE_LEN_DEF,
  parameter int unsigned GAP_LEN   = GAP_LEN_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x,
  input  logic             y,
  input  logic             drop_ok,
  output logic             motor,
  output logic             coin_ret,
  output logic             busy,
  output logic             fault,
  output logic             ovf,
  output logic [CNT_W-1:0] pend_prod,
  output logic [CNT_W-1:0] pend_chg
);

  localparam int unsigned TMR_W = timer_width(TIMEOUT, PULSE_LEN, GAP_LEN);
  localparam logic [TMR_W-1:0] TOUT_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_LEN - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_LEN - 1);

  state_e           state_q;
  logic [TMR_W-1:0] timer_q;
  logic             motor_q;
  logic             coin_ret_q;
  logic             busy_q;
  logic             fault_q;
  logic             ovf_q;

  logic [CNT_W-1:0] pend_prod_cnt;
  logic [CNT_W-1:0] pend_chg_cnt;
  logic             ovf_prod;
  logic             ovf_chg;
  logic             disp_prod;
  logic             disp_chg;

  // Dispatch decisions feed the counters' decrement in the same edge the FSM leaves IDLE.
  assign disp_prod = (state_q == IDLE) && (pend_prod_cnt != '0);
  assign disp_chg  = (state_q == IDLE) && (pend_prod_cnt == '0) && (pend_chg_cnt != '0);

  vend_req_cnt #(.W(CNT_W)) u_prod_cnt (
    .clk     (clock),
    .srst    (reset),
    .inc_i   (x),
    .dec_i   (disp_prod),
    .count_o (pend_prod_cnt),
    .ovf_o   (ovf_prod)
  );

  vend_req_cnt #(.W(CNT_W)) u_chg_cnt (
    .clk     (clock),
    .srst    (reset),
    .inc_i   (y),
    .dec_i   (disp_chg),
    .count_o (pend_chg_cnt),
    .ovf_o   (ovf_chg)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      motor_q    <= 1'b0;
      coin_ret_q <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ovf_prod | ovf_chg;
      case (state_q)
        IDLE: begin
          if (disp_prod) begin
            state_q <= PROD;
            motor_q <= 1'b1;
            busy_q  <= 1'b1;
            timer_q <= '0;
          end else if (disp_chg) begin
            state_q    <= CHG;
            coin_ret_q <= 1'b1;
            busy_q     <= 1'b1;
            timer_q    <= '0;
          end
        end
        PROD: begin
          // A drop on the timeout edge still counts as a successful vend.
          if (drop_ok) begin
            state_q <= GAP;
            motor_q <= 1'b0;
            timer_q <= '0;
          end else if (timer_q == TOUT_LAST) begin
            state_q <= FAULT;
            motor_q <= 1'b0;
            fault_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        CHG: begin
          if (timer_q == PULSE_LAST) begin
            state_q    <= GAP;
            coin_ret_q <= 1'b0;
            timer_q    <= '0;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        GAP: begin
          if (timer_q == GAP_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        FAULT: begin
          state_q    <= FAULT;
          motor_q    <= 1'b0;
          coin_ret_q <= 1'b0;
          busy_q     <= 1'b1;
          fault_q    <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          motor_q    <= 1'b0;
          coin_ret_q <= 1'b0;
          busy_q     <= 1'b0;
          timer_q    <= '0;
        end
      endcase
    end
  end

  assign motor     = motor_q;
  assign coin_ret  = coin_ret_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign ovf       = ovf_q;
  assign pend_prod = pend_prod_cnt;
  assign pend_chg  = pend_chg_cnt;

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed bench for vend_dispenser: hand-computed cycle-by-cycle expectations
// for vend, change, overflow, timeout, mid-pulse reset and saturation cases.
module tb_vend_dispenser;

  logic       clock;
  logic       reset;
  logic       x;
  logic       y;
  logic       drop_ok;
  logic       motor;
  logic       coin_ret;
  logic       busy;
  logic       fault;
  logic       ovf;
  logic [1:0] pend_prod;
  logic [1:0] pend_chg;

  int n_cmp = 0;
  int n_err = 0;

  vend_dispenser dut (
    .clock     (clock),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .drop_ok   (drop_ok),
    .motor     (motor),
    .coin_ret  (coin_ret),
    .busy      (busy),
    .fault     (fault),
    .ovf       (ovf),
    .pend_prod (pend_prod),
    .pend_chg  (pend_chg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  int rises;
  logic prev_coin;

  initial begin
    reset = 1'b1; x = 1'b0; y = 1'b0; drop_ok = 1'b0;
    @(negedge clock);

    // Reset state
    step(); step();
    chk("rst_motor", motor, 0);
    chk("rst_coin", coin_ret, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_pprod", pend_prod, 0);
    chk("rst_pchg", pend_chg, 0);
    reset = 1'b0;
    $display("txn: reset checked");

    // Single product vend, drop three cycles after motor rises
    x = 1'b1; step(); x = 1'b0;
    chk("v1_pprod1", pend_prod, 1);
    chk("v1_motor_pre", motor, 0);
    step();
    chk("v1_motor_on", motor, 1);
    chk("v1_pprod0", pend_prod, 0);
    chk("v1_busy_on", busy, 1);
    step(); chk("v1_motor_c2", motor, 1);
    step(); chk("v1_motor_c3", motor, 1);
    drop_ok = 1'b1; step(); drop_ok = 1'b0;
    chk("v1_motor_off", motor, 0);
    chk("v1_gap_busy1", busy, 1);
    step(); chk("v1_gap_busy2", busy, 1);
    step(); chk("v1_idle_busy", busy, 0);
    chk("v1_fault", fault, 0);
    $display("txn: single product vend");

    // Simultaneous product and change
    x = 1'b1; y = 1'b1; step(); x = 1'b0; y = 1'b0;
    chk("v2_pprod", pend_prod, 1);
    chk("v2_pchg", pend_chg, 1);
    step();
    chk("v2_motor", motor, 1);
    chk("v2_pchg_hold", pend_chg, 1);
    drop_ok = 1'b1; step(); drop_ok = 1'b0;
    chk("v2_motor_off", motor, 0);
    step(); chk("v2_gap_coin", coin_ret, 0);
    step(); chk("v2_idle_coin", coin_ret, 0);
    chk("v2_idle_busy", busy, 0);
    step();
    chk("v2_coin_rise", coin_ret, 1);
    chk("v2_pchg0", pend_chg, 0);
    for (int i = 0; i < 3; i++) begin
      step(); chk("v2_coin_hold", coin_ret, 1);
    end
    step(); chk("v2_coin_fall", coin_ret, 0);
    chk("v2_busy_gap", busy, 1);
    step(); chk("v2_busy_gap2", busy, 1);
    step(); chk("v2_busy_fall", busy, 0);
    $display("txn: product + change");

    // Change overflow while a product actuation blocks dispatch
    x = 1'b1; step(); x = 1'b0;
    step(); chk("v3_motor", motor, 1);
    y = 1'b1;
    step(); chk("v3_pchg1", pend_chg, 1);
    step(); chk("v3_pchg2", pend_chg, 2);
    step(); chk("v3_pchg3", pend_chg, 3);
    chk("v3_ovf_pre", ovf, 0);
    step(); chk("v3_pchg_sat", pend_chg, 3);
    chk("v3_ovf_set", ovf, 1);
    step(); chk("v3_pchg_sat2", pend_chg, 3);
    y = 1'b0;
    drop_ok = 1'b1; step(); drop_ok = 1'b0;
    chk("v3_motor_off", motor, 0);
    rises = 0; prev_coin = coin_ret;
    for (int i = 0; i < 60; i++) begin
      step();
      if (coin_ret && !prev_coin) rises++;
      prev_coin = coin_ret;
    end
    chk("v3_coin_pulses", rises, 3);
    chk("v3_pchg_end", pend_chg, 0);
    chk("v3_ovf_sticky", ovf, 1);
    chk("v3_busy_end", busy, 0);
    $display("txn: change overflow");

    // Motor timeout leads to sticky fault
    do_reset();
    chk("v4_ovf_clr", ovf, 0);
    x = 1'b1; step(); x = 1'b0;
    step(); chk("v4_motor_c1", motor, 1);
    for (int i = 0; i < 15; i++) begin
      step(); chk("v4_motor_hold", motor, 1);
    end
    step();
    chk("v4_motor_off", motor, 0);
    chk("v4_fault", fault, 1);
    chk("v4_busy", busy, 1);
    y = 1'b1; step(); y = 1'b0;
    chk("v4_pchg1", pend_chg, 1);
    for (int i = 0; i < 10; i++) step();
    chk("v4_pchg_stuck", pend_chg, 1);
    chk("v4_coin_off", coin_ret, 0);
    chk("v4_fault_sticky", fault, 1);
    $display("txn: motor timeout");

    // Reset in the middle of a coin-return pulse
    do_reset();
    chk("v5_fault_clr", fault, 0);
    y = 1'b1; step(); y = 1'b0;
    x = 1'b1;
    step(); chk("v5_coin_c1", coin_ret, 1);
    step(); chk("v5_coin_c2", coin_ret, 1);
    chk("v5_pprod2", pend_prod, 2);
    reset = 1'b1; step();
    chk("v5_coin", coin_ret, 0);
    chk("v5_busy", busy, 0);
    chk("v5_pprod", pend_prod, 0);
    chk("v5_pchg", pend_chg, 0);
    chk("v5_motor", motor, 0);
    reset = 1'b0; x = 1'b0;
    step();
    chk("v5_idle_busy", busy, 0);
    chk("v5_idle_motor", motor, 0);
    $display("txn: reset mid-pulse");

    // Saturated product counter with simultaneous dispatch and strobe
    y = 1'b1; step(); y = 1'b0;
    chk("v6_pchg1", pend_chg, 1);
    x = 1'b1;
    step(); chk("v6_coin", coin_ret, 1); chk("v6_pprod1", pend_prod, 1);
    step(); chk("v6_pprod2", pend_prod, 2);
    step(); chk("v6_pprod3", pend_prod, 3);
    x = 1'b0;
    step(); step(); step(); step();
    chk("v6_idle_busy", busy, 0);
    chk("v6_pprod_held", pend_prod, 3);
    x = 1'b1; step();
    chk("v6_motor", motor, 1);
    chk("v6_pprod_same", pend_prod, 3);
    chk("v6_ovf_clear", ovf, 0);
    step(); x = 1'b0;
    chk("v6_pprod_sat", pend_prod, 3);
    chk("v6_ovf_set", ovf, 1);
    $display("txn: product saturation");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
